// File: rtl/tff_seq_pkg.sv
// Shared state encoding and direction constants for the toggle-counter sequencer.
package tff_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/tff_cell.sv
// Single falling-edge toggle flip-flop with synchronous active-high clear.
module tff_cell (
  input  logic clk_i,
  input  logic rst_i,
  input  logic t_i,
  output logic q_o
);

  logic q_q;
  logic q_d;

  assign q_d = q_q ^ t_i;

  always_ff @(negedge clk_i) begin
    if (rst_i) q_q <= 1'b0;
    else       q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/tff_counter_sequencer.sv
// Sequences a bank of toggle cells as an up/down counter for a programmed step count.
// TFF_SATURATE_EN: stop at all-ones/zero instead of wrapping, ending the run early.
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | stepping once per unpaused edge
//   DONE  | one-cycle completion marker
module tff_counter_sequencer
  import tff_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] count_len,
  input  logic             pause,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t_vec,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH-1:0] tv_raw;
  logic             carry;
  logic             at_limit;
  logic             stepping;
  logic             step_ok;

  // Ripple of the carry/borrow chain; the chain's tail means the next step wraps.
  always_comb begin
    carry  = 1'b1;
    tv_raw = '0;
    for (int i = 0; i < WIDTH; i++) begin
      tv_raw[i] = carry;
      carry     = carry & ((dir_q == DIR_UP) ? q[i] : ~q[i]);
    end
    at_limit = carry;
  end

  assign stepping = (state_q == RUN) && !pause;

`ifdef TFF_SATURATE_EN
  assign step_ok = stepping && !at_limit;
  assign wrap_d  = 1'b0;
`else
  assign step_ok = stepping;
  assign wrap_d  = step_ok && at_limit;
`endif

  assign t_vec = step_ok ? tv_raw : '0;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (count_len != '0) begin
            dir_d   = dir;
            rem_d   = count_len;
            state_d = RUN;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (stepping) begin
`ifdef TFF_SATURATE_EN
          if (at_limit) begin
            state_d = DONE;
          end else begin
            rem_d = rem_q - WIDTH'(1);
            if (rem_q == WIDTH'(1)) state_d = DONE;
          end
`else
          rem_d = rem_q - WIDTH'(1);
          if (rem_q == WIDTH'(1)) state_d = DONE;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      dir_q   <= DIR_DOWN;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .clk_i (clk),
      .rst_i (rst),
      .t_i   (t_vec[i]),
      .q_o   (q[i])
    );
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign wrap = wrap_q;

endmodule

// File: tb/tb_tff_counter_sequencer.sv
// Scoreboard bench for tff_counter_sequencer at WIDTH=4; expectations are queued per cycle.
module tb_tff_counter_sequencer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst, start, dir, pause;
  logic [W-1:0] count_len;
  logic [W-1:0] q, t_vec;
  logic         busy, done, wrap;

  typedef struct {
    logic [W-1:0] q;
    logic         busy;
    logic         done;
    logic         wrap;
    logic [W-1:0] tv;
  } exp_t;

  exp_t  sbq[$];
  int    n_cmp = 0;
  int    n_err = 0;
  string cur = "reset";

  tff_counter_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dir       (dir),
    .count_len (count_len),
    .pause     (pause),
    .q         (q),
    .t_vec     (t_vec),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] nxt(input logic [W-1:0] v, input logic up);
    return up ? v + W'(1) : v - W'(1);
  endfunction

  task automatic push(input logic [W-1:0] eq, input logic eb, input logic ed,
                      input logic ew, input logic [W-1:0] etv);
    exp_t e;
    e.q = eq; e.busy = eb; e.done = ed; e.wrap = ew; e.tv = etv;
    sbq.push_back(e);
  endtask

  // Expected cycle-by-cycle trace for an unpaused, non-saturating run.
  task automatic push_run(input logic [W-1:0] q0, input logic up, input int len);
    logic [W-1:0] v;
    logic         w;
    v = q0;
    w = 1'b0;
    if (len == 0) begin
      push(q0, 1'b1, 1'b1, 1'b0, '0);
      push(q0, 1'b0, 1'b0, 1'b0, '0);
      return;
    end
    for (int k = 0; k < len; k++) begin
      push(v, 1'b1, 1'b0, w, v ^ nxt(v, up));
      w = up ? (v == '1) : (v == '0);
      v = nxt(v, up);
    end
    push(v, 1'b1, 1'b1, w, '0);
    push(v, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // Let one falling edge act, then compare at the following rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    @(posedge clk);
    if (sbq.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s sb_empty: got no expectation expected one queued", cur);
    end else begin
      e = sbq.pop_front();
      check({cur, " q"},     32'(q),     32'(e.q));
      check({cur, " busy"},  32'(busy),  32'(e.busy));
      check({cur, " done"},  32'(done),  32'(e.done));
      check({cur, " wrap"},  32'(wrap),  32'(e.wrap));
      check({cur, " t_vec"}, 32'(t_vec), 32'(e.tv));
    end
  endtask

  task automatic drive_run(input logic up, input int len);
    start = 1'b1; dir = up; count_len = W'(len);
    tick();
    start = 1'b0;
    repeat ((len == 0) ? 1 : len + 1) tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dir = 1'b0; pause = 1'b0; count_len = '0;

    cur = "reset";
    push('0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    rst = 1'b0;

    cur = "up5";
    push_run(4'd0, 1'b1, 5);
    drive_run(1'b1, 5);

    cur = "zero_len";
    push_run(4'd5, 1'b1, 0);
    drive_run(1'b1, 0);

    // Start pulsed mid-run and again on the DONE edge must both be ignored.
    cur = "ign_start";
    push_run(4'd5, 1'b1, 3);
    push(4'd8, 1'b0, 1'b0, 1'b0, '0);
    start = 1'b1; dir = 1'b1; count_len = 4'd3;
    tick();
    dir = 1'b0; count_len = 4'd9;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1; dir = 1'b1; count_len = 4'd3;
    tick();
    start = 1'b0;
    tick();

    cur = "pre_pause";
    rst = 1'b1;
    push('0, 1'b0, 1'b0, 1'b0, '0);
    tick();
    rst = 1'b0;
    push_run(4'd0, 1'b1, 2);
    drive_run(1'b1, 2);

    cur = "pause";
    push(4'd2, 1'b1, 1'b0, 1'b0, 4'd1);
    push(4'd3, 1'b1, 1'b0, 1'b0, 4'd7);
    repeat (3) push(4'd3, 1'b1, 1'b0, 1'b0, 4'd0);
    push(4'd4, 1'b1, 1'b0, 1'b0, 4'd1);
    push(4'd5, 1'b1, 1'b0, 1'b0, 4'd3);
    push(4'd6, 1'b1, 1'b1, 1'b0, 4'd0);
    push(4'd6, 1'b0, 1'b0, 1'b0, 4'd0);
    start = 1'b1; dir = 1'b1; count_len = 4'd4; pause = 1'b0;
    tick();
    start = 1'b0;
    tick();
    pause = 1'b1;
    repeat (3) tick();
    pause = 1'b0;
    repeat (4) tick();

    cur = "rst_midrun";
    for (int k = 6; k < 10; k++) push(W'(k), 1'b1, 1'b0, 1'b0, W'(k) ^ W'(k + 1));
    push('0, 1'b0, 1'b0, 1'b0, '0);
    push('0, 1'b0, 1'b0, 1'b0, '0);
    start = 1'b1; dir = 1'b1; count_len = 4'd10;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

`ifdef TFF_SATURATE_EN
    cur = "sat_pre";
    push_run(4'd0, 1'b1, 14);
    drive_run(1'b1, 14);

    cur = "sat_up";
    push(4'd14, 1'b1, 1'b0, 1'b0, 4'd1);
    push(4'd15, 1'b1, 1'b0, 1'b0, 4'd0);
    push(4'd15, 1'b1, 1'b1, 1'b0, 4'd0);
    push(4'd15, 1'b0, 1'b0, 1'b0, 4'd0);
    start = 1'b1; dir = 1'b1; count_len = 4'd5;
    tick();
    start = 1'b0;
    repeat (3) tick();
`else
    cur = "down_wrap";
    push_run(4'd0, 1'b0, 3);
    drive_run(1'b0, 3);
`endif

    check("sb_drain", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tff_counter_sequencer.md
Name: tff_counter_sequencer

Overview:
- Controller that sequences a bank of WIDTH toggle flip-flops as a synchronous up/down counter.
- Generates the per-bit toggle vector from the current bank state and direction, and runs a programmed number of count steps on command.
- Supports pause and reports completion and wrap-around.
- Sits beside the team's toggle-flip-flop datapath; used for timed sequences and event counting.

Parameters:
- WIDTH, 8: counter bits, which is the number of toggle cells in the bank.

Ports:
- clk  input  1  clock; all state updates on the falling edge.
- rst  input  1  synchronous active-high reset, sampled on the falling edge of clk.
- start  input  1  begin a run of count_len steps; honoured only in IDLE.
- dir  input  1  1 = count up, 0 = count down; sampled and held at start.
- count_len  input  WIDTH  number of steps for the run; sampled at start.
- pause  input  1  while high in RUN: no toggles, step count held.
- q  output  WIDTH  current counter value (toggle bank outputs).
- t_vec  output  WIDTH  toggle vector applied this cycle (combinational).
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse marking end of run.
- wrap  output  1  registered one-cycle pulse after q wrapped.

Behaviour:
- Reset state: q=0, state=IDLE, busy=0, done=0, wrap=0, t_vec=0, remaining=0, dir_r=0.
- rst has priority over everything, including mid-run; the run is abandoned with no done pulse.
- Toggle rule for up counting: t[0]=1; t[i]=&q[i-1:0].
- Toggle rule for down counting: t[0]=1; t[i]=&~q[i-1:0].
- t_vec equals that toggle vector only when state=RUN and pause=0; otherwise t_vec=0.
- Each toggle cell updates q[i] <= q[i]^t_vec[i] at each falling edge.
- IDLE, start=1, count_len!=0: latch dir_r and remaining<=count_len, go to RUN. No toggle occurs on this edge.
- IDLE, start=1, count_len=0: go directly to DONE. q is unchanged.
- RUN, pause=0: one step per edge and remaining decrements. When remaining==1 on a stepping edge, go to DONE.
- RUN, pause=1: stay in RUN; q and remaining hold.
- DONE: done=1 (decoded from state) for exactly one cycle, then return to IDLE on the next edge.
- start while busy is ignored, with no queuing. start held high in the DONE cycle is also ignored; a new run needs start sampled in IDLE.
- Latency: for count_len=N with no pause, the start edge is followed by N stepping edges, and done is high in the cycle after the Nth step. busy is high for N+1 cycles.
- Wrap (up): a step from all-ones to 0 sets wrap=1 for one cycle.
- Wrap (down): a step from 0 to all-ones sets wrap=1 for one cycle.
- Wrap does not end the run.
- q is never cleared by start; runs continue from the current value.

Optional Feature:
- Macro: TFF_SATURATE_EN.
- Defined: counting saturates at all-ones (up) or 0 (down). A step that would wrap is suppressed (t_vec=0 that cycle) and the FSM goes straight to DONE, ending the run early. wrap is tied to 0.
- Undefined: modulo-2^WIDTH wrap behaviour as above.

Decomposition:
- Shared package tff_seq_pkg holds:
  - the state encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the direction constants DIR_UP=1'b1 and DIR_DOWN=1'b0.
- Sub-module tff_cell: a single falling-edge toggle flip-flop with synchronous active-high reset to 0. It is instantiated WIDTH times via generate.
- FSM, step counter and toggle-vector logic stay in the top module.

Test Plan:
- Reset mid-run: WIDTH=4, start up with count_len=10, assert rst after 3 steps -> next cycle q=0, busy=0, done never pulses, state IDLE.
- Up count: q=0, start dir=1 count_len=5 -> q steps 1..5 on consecutive edges, done high exactly one cycle after q=5, busy high 6 cycles.
- Down wrap: q=0, start dir=0 count_len=3 -> q=15,14,13; wrap pulses once after q=15; done after 13.
- Pause: q=2, start up count_len=4, pause high for 3 cycles after first step -> q holds at 3 during pause, finishes at 6, busy extended by 3 cycles.
- Zero length and ignored start: start count_len=0 -> done pulse next cycle, q unchanged; start pulsed during RUN -> no effect on remaining or dir.
- TFF_SATURATE_EN: q=14, start up count_len=5 -> q=15, then DONE early with t_vec=0 on the blocked step; wrap stays 0.
